uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial-to-parallel UART receiver: the receive end of the link driven by uart_tx.
//  Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity; idle line = 1.
//  Oversamples rx_data at CLKS_PER_BIT clocks per bit and samples each bit at mid-bit.
//  Holds each received byte until the consumer acknowledges it, and flags framing errors and overruns.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit; legal range >= 4; HALF = CLKS_PER_BIT/2 (floor)
// PORTS
//  clk          in   1  system clock; single clock domain
//  reset        in   1  synchronous, active-low reset
//  rx_data      in   1  asynchronous serial input line
//  rx_ack       in   1  consumer pulse: byte in data_out has been taken
//  data_out     out  8  last good received byte
//  rx_valid     out  1  data_out holds an unacknowledged byte (level)
//  rx_busy      out  1  frame reception in progress
//  frame_error  out  1  one-cycle pulse: stop bit sampled 0
//  rx_overrun   out  1  sticky: a good byte was dropped while rx_valid=1
// BEHAVIOUR
//  Clocking/reset: one clock; reset is synchronous and active-low.
//   reset=0 at an edge -> state IDLE; data_out=0, rx_valid=0, rx_busy=0, frame_error=0, rx_overrun=0.
//   At the same edge, counters clear, and sync1, sync2 and prev load 1. Reset mid-frame discards the partial byte.
//  Sync: rx_data -> sync1 -> sync2 (2-flop); prev = sync2 delayed 1 cycle. All FSM logic uses sync2 only.
//  FSM states: IDLE, START, DATA, STOP.
//   IDLE: at the edge where prev=1 and sync2=0 (call it t0) -> START; clear the bit counter.
//    Edge-detect only: a line held low, such as a break, does not re-trigger.
//    If rx_data is low at reset release, a start is detected at t0 = the 3rd edge after release.
//   START: sample sync2 at t0+HALF. If 0 -> DATA. If 1 -> false start: return to IDLE with no outputs changed.
//   DATA: data bit i (i=0..7) is sampled at t0+HALF+(i+1)*CLKS_PER_BIT.
//    Each sample shifts into shreg from the MSB end, so bit 0 ends up in shreg[0].
//    After bit 7 -> STOP.
//   STOP: stop bit is sampled at ts = t0+HALF+9*CLKS_PER_BIT; then -> IDLE at the same edge.
//    sample=1 -> good byte.
//    sample=0 -> frame_error=1 for exactly one cycle; data_out, rx_valid and rx_overrun are unchanged.
//  rx_busy = 1 in START, DATA and STOP; 0 in IDLE.
//  Good-byte delivery is registered at edge ts (visible in the cycle after ts):
//   rx_valid=0                         -> data_out=shreg, rx_valid=1.
//   rx_valid=1, rx_ack=0               -> byte dropped; data_out kept; rx_overrun=1.
//   rx_valid=1, rx_ack=1 in same cycle -> data_out=shreg, rx_valid stays 1, no overrun.
//  rx_ack with rx_valid=1 and no delivery -> rx_valid=0 and rx_overrun=0 next edge; data_out holds.
//  rx_ack with rx_valid=0 -> ignored.
//  Receiver keeps receiving while rx_valid=1; there is no back-pressure on the line.
//  A new start edge is accepted from the first edge after ts, which gives back-to-back frames with 1 stop bit.
//  Tolerance: sampling mid-bit gives about +/-HALF clocks of cumulative drift over 10 bits.
//  Counter width: $clog2(CLKS_PER_BIT)+1 bits; bit counter 3 bits; no wrap inside a frame.
// TESTING (CLKS_PER_BIT=16, bit period 16 clk, data 8'h27)
//  Reset: hold reset=0 with rx_data toggling.
//   -> all outputs 0; state stays IDLE.
//  Single frame 0x27 (line bits 0,1,1,1,0,0,1,0,0,1):
//   -> data_out=8'h27 and rx_valid=1 visible the cycle after t0+152.
//   -> rx_busy high from t0+1 through t0+152.
//  Glitch: rx_data low for 4 clk, then high.
//   -> START aborts at t0+8; rx_busy falls; rx_valid stays 0; no frame_error.
//  Bad stop: frame 0xA5 with stop bit 0.
//   -> frame_error pulses 1 cycle; rx_valid=0; data_out unchanged.
//   Line held low afterwards -> no new start until a 1->0 edge.
//  Overrun: 0x27 then 0x3C back-to-back, no rx_ack.
//   -> data_out=8'h27, rx_overrun=1.
//   rx_ack -> rx_valid=0, rx_overrun=0.
//   Repeat with rx_ack at the 2nd ts edge -> data_out=8'h3C, rx_valid=1, no overrun.
//  Reset mid-frame: reset=0 during DATA bit 4.
//   -> IDLE; no byte delivered; the next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, oversampled at CLKS_PER_BIT, mid-bit sampling,
// single-entry holding register with framing-error and overrun reporting.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_data,
    input  logic       rx_ack,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_error,
    output logic       rx_overrun
);

    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_cnt, bit_cnt_next;
    logic [7:0]       shreg, shreg_next;
    logic             sync1, sync2, prev;

    logic [7:0]       data_out_next;
    logic             rx_valid_next;
    logic             rx_busy_next;
    logic             frame_error_next;
    logic             rx_overrun_next;
    logic             good_byte;

    // State, counters, synchroniser and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            prev        <= 1'b1;
            data_out    <= '0;
            rx_valid    <= 1'b0;
            rx_busy     <= 1'b0;
            frame_error <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            bit_cnt     <= bit_cnt_next;
            shreg       <= shreg_next;
            sync1       <= rx_data;
            sync2       <= sync1;
            prev        <= sync2;
            data_out    <= data_out_next;
            rx_valid    <= rx_valid_next;
            rx_busy     <= rx_busy_next;
            frame_error <= frame_error_next;
            rx_overrun  <= rx_overrun_next;
        end
    end

    // Next-state, sampling and delivery logic
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        bit_cnt_next     = bit_cnt;
        shreg_next       = shreg;
        data_out_next    = data_out;
        rx_valid_next    = rx_valid;
        frame_error_next = 1'b0;
        rx_overrun_next  = rx_overrun;
        good_byte        = 1'b0;

        case (state)
            S_IDLE: begin
                // Falling edge only: a line held low never re-arms the receiver
                if (prev && !sync2) begin
                    state_next   = S_START;
                    cnt_next     = '0;
                    bit_cnt_next = '0;
                end
            end
            S_START: begin
                if (cnt == CNT_W'(HALF - 1)) begin
                    cnt_next   = '0;
                    state_next = sync2 ? S_IDLE : S_DATA;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_next     = '0;
                    shreg_next   = {sync2, shreg[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = S_STOP;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                    if (sync2) begin
                        good_byte = 1'b1;
                    end else begin
                        frame_error_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // An ack in the delivery cycle frees the slot for the new byte
        if (good_byte) begin
            if (!rx_valid || rx_ack) begin
                data_out_next   = shreg;
                rx_valid_next   = 1'b1;
                rx_overrun_next = 1'b0;
            end else begin
                rx_overrun_next = 1'b1;
            end
        end else if (rx_valid && rx_ack) begin
            rx_valid_next   = 1'b0;
            rx_overrun_next = 1'b0;
        end

        rx_busy_next = (state_next != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed timing cases plus randomized frames checked by a
// queue-based scoreboard fed from the stimulus side.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned C = 16;

    logic       clk;
    logic       reset;
    logic       rx_data;
    logic       rx_ack;
    logic       ack_mon;
    logic       ack_dir;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_error;
    logic       rx_overrun;

    int         checks;
    int         errors;
    int         fe_seen;
    int         fe_expected;
    logic       auto_ack;
    logic [7:0] exp_q[$];

    assign rx_ack = ack_mon | ack_dir;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_ack     (rx_ack),
        .data_out   (data_out),
        .rx_valid   (rx_valid),
        .rx_busy    (rx_busy),
        .frame_error(frame_error),
        .rx_overrun (rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line-level frame: start 0, 8 bits LSB first, stop bit as given
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_data = bits[i];
            wait_cyc(C);
        end
    endtask

    // Scoreboard monitor: every byte delivery pops the oldest expected byte
    initial begin
        logic       last_valid;
        logic [7:0] last_data;
        logic       last_fe;
        logic [7:0] e;
        last_valid = 1'b0;
        last_data  = '0;
        last_fe    = 1'b0;
        ack_mon    = 1'b0;
        forever begin
            @(negedge clk);
            ack_mon = 1'b0;
            if (!reset) begin
                last_valid = 1'b0;
                last_data  = '0;
                last_fe    = 1'b0;
            end else begin
                if (rx_valid && (!last_valid || data_out != last_data)) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_byte: got %02h expected none", data_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (data_out !== e) begin
                            errors++;
                            $display("FAIL byte: got %02h expected %02h", data_out, e);
                        end
                    end
                    if (auto_ack) ack_mon = 1'b1;
                end
                if (frame_error) begin
                    fe_seen++;
                    checks++;
                    if (last_fe) begin
                        errors++;
                        $display("FAIL fe_width: got pulse longer than 1 cycle expected 1 cycle");
                    end
                end
                last_valid = rx_valid;
                last_data  = data_out;
                last_fe    = frame_error;
            end
        end
    end

    initial begin
        int kind;
        int gap;
        logic [7:0] b;
        logic [7:0] part;
        checks      = 0;
        errors      = 0;
        fe_seen     = 0;
        fe_expected = 0;
        auto_ack    = 1'b1;
        ack_dir     = 1'b0;
        reset       = 1'b0;
        rx_data     = 1'b1;

        // Reset held with a toggling line
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 rx_data = ~rx_data;
        end
        chk("reset_outputs", {data_out, rx_valid, rx_busy, frame_error, rx_overrun}, 32'h0);
        rx_data = 1'b1;
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(5);
        chk("post_reset_idle", {rx_valid, rx_busy, frame_error, rx_overrun}, 32'h0);

        // Single frame 0x27 with cycle-exact timing
        exp_q.push_back(8'h27);
        fork
            send_frame(8'h27, 1'b1);
            begin
                wait_cyc(2);
                chk("busy_before_t0", rx_busy, 1'b0);
                wait_cyc(1);
                chk("busy_at_t0", rx_busy, 1'b1);
                wait_cyc(151);
                chk("busy_t0p151", rx_busy, 1'b1);
                chk("valid_t0p151", rx_valid, 1'b0);
                wait_cyc(1);
                chk("busy_ts", rx_busy, 1'b0);
                chk("valid_ts", rx_valid, 1'b1);
                chk("data_ts", data_out, 8'h27);
            end
        join
        wait_cyc(5);
        chk("acked_valid", rx_valid, 1'b0);

        // Bad stop bit, line then held low
        fe_expected++;
        send_frame(8'hA5, 1'b0);
        wait_cyc(40);
        chk("badstop_busy", rx_busy, 1'b0);
        chk("badstop_valid", rx_valid, 1'b0);
        chk("badstop_data", data_out, 8'h27);
        chk("badstop_ovr", rx_overrun, 1'b0);
        chk("badstop_fe_count", fe_seen, fe_expected);
        rx_data = 1'b1;
        wait_cyc(5);

        // Glitch: 4 clocks low
        rx_data = 1'b0;
        fork
            begin
                wait_cyc(4);
                rx_data = 1'b1;
            end
            begin
                wait_cyc(10);
                chk("glitch_busy_t0p7", rx_busy, 1'b1);
                wait_cyc(1);
                chk("glitch_busy_t0p8", rx_busy, 1'b0);
            end
        join
        wait_cyc(20);
        chk("glitch_valid", rx_valid, 1'b0);
        chk("glitch_fe_count", fe_seen, fe_expected);

        // Overrun: two back-to-back frames without ack
        auto_ack = 1'b0;
        exp_q.push_back(8'h27);
        send_frame(8'h27, 1'b1);
        send_frame(8'h3C, 1'b1);
        wait_cyc(10);
        chk("ovr_data", data_out, 8'h27);
        chk("ovr_valid", rx_valid, 1'b1);
        chk("ovr_flag", rx_overrun, 1'b1);
        ack_dir = 1'b1;
        wait_cyc(1);
        ack_dir = 1'b0;
        chk("ovr_ack_valid", rx_valid, 1'b0);
        chk("ovr_ack_flag", rx_overrun, 1'b0);
        chk("ovr_ack_data", data_out, 8'h27);

        // Ack coinciding with the second delivery edge
        exp_q.push_back(8'h27);
        exp_q.push_back(8'h3C);
        fork
            begin
                send_frame(8'h27, 1'b1);
                send_frame(8'h3C, 1'b1);
            end
            begin
                wait_cyc(2 * 10 * C - 6);
                ack_dir = 1'b1;
                wait_cyc(1);
                ack_dir = 1'b0;
                chk("ackts_data", data_out, 8'h3C);
                chk("ackts_valid", rx_valid, 1'b1);
                chk("ackts_ovr", rx_overrun, 1'b0);
            end
        join
        ack_dir = 1'b1;
        wait_cyc(1);
        ack_dir = 1'b0;
        chk("ackts_clear", rx_valid, 1'b0);
        auto_ack = 1'b1;

        // Reset during data bit 4
        part    = 8'h99;
        rx_data = 1'b0;
        wait_cyc(C);
        for (int i = 0; i < 4; i++) begin
            rx_data = part[i];
            wait_cyc(C);
        end
        rx_data = part[4];
        wait_cyc(C / 2);
        reset   = 1'b0;
        rx_data = 1'b1;
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(30);
        chk("midreset_outputs", {data_out, rx_valid, rx_busy, rx_overrun}, 32'h0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_cyc(10);
        chk("midreset_next_frame_q", exp_q.size(), 0);

        // Randomized traffic: good frames, bad stops and glitches
        for (int n = 0; n < 30; n++) begin
            kind = int'($urandom_range(0, 9));
            gap  = int'($urandom_range(0, 20));
            b    = 8'($urandom);
            if (kind == 0) begin
                rx_data = 1'b0;
                wait_cyc(int'($urandom_range(1, 4)));
                rx_data = 1'b1;
                wait_cyc(14 + gap);
            end else if (kind == 1) begin
                fe_expected++;
                send_frame(b, 1'b0);
                rx_data = 1'b1;
                wait_cyc(3 + gap);
            end else begin
                exp_q.push_back(b);
                send_frame(b, 1'b1);
                if (gap > 0) wait_cyc(gap);
            end
        end

        for (int i = 0; i < 400 && exp_q.size() != 0; i++) wait_cyc(1);
        wait_cyc(5);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_fe_count", fe_seen, fe_expected);
        chk("final_overrun", rx_overrun, 1'b0);
        chk("final_busy", rx_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
